i2c_reg_slave: RTL and testbench



---
 rtl/i2c_reg_slave.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_i2c_reg_slave.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_slave.sv
// i2c_reg_slave: I2C target for the camera register-write protocol.
// A transaction is [0xBA, 8-bit sub-address, 16-bit data MSB first]; every
// completed 16-bit word produces one reg_wr strobe, then reg_addr advances so
// further words form a burst. SCL/SDA are oversampled on clock, synchronized,
// glitch filtered, and START/STOP are decoded from the filtered levels.
//
// Optional feature: define I2C_SLAVE_READ_EN to ACK the read address
// {SLAVE_ADDR,1} and shift reg_rdata out on SDA. Without it the read address
// is NACKed and counted in nack_count.
//
// Ports:
//   clock        system clock
//   reset_n      asynchronous active-low reset
//   i2c_sclk     SCL line (asynchronous)
//   i2c_sdat_in  SDA line level (asynchronous)
//   i2c_sdat_oe  1 = pull SDA low, 0 = release
//   reg_wr       one-cycle register write strobe
//   reg_addr     register address (write address, and read address)
//   reg_wdata    write data, valid with reg_wr
//   reg_rdata    read data for reg_addr (read feature only)
//   busy         high from accepted START until STOP
//   nack_count   saturating count of address-mismatch transactions
module i2c_reg_slave #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h5D,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i2c_sclk,
    input  logic        i2c_sdat_in,
    output logic        i2c_sdat_oe,
    output logic        reg_wr,
    output logic [7:0]  reg_addr,
    output logic [15:0] reg_wdata,
    input  logic [15:0] reg_rdata,
    output logic        busy,
    output logic [7:0]  nack_count
);

    localparam logic [2:0] FILT_LAST = 3'(FILTER_LEN - 1);
    localparam logic [7:0] ADDR_WR   = {SLAVE_ADDR, 1'b0};
`ifdef I2C_SLAVE_READ_EN
    localparam logic [7:0] ADDR_RD   = {SLAVE_ADDR, 1'b1};
`endif

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        SUB,
        SUB_ACK,
        DHI,
        DHI_ACK,
        DLO,
        DLO_ACK,
        RD_HI,
        RD_HI_MACK,
        RD_LO,
        RD_LO_MACK,
        WAIT_STOP
    } state_t;

    // Index 0 = SCL, index 1 = SDA throughout the input path.
    logic [1:0]      w_pins;
    logic [1:0]      r_sync1;
    logic [1:0]      r_sync2;
    logic [1:0]      r_filt;
    logic [1:0]      r_filt_d;
    logic [1:0][2:0] r_fcnt;

    assign w_pins = {i2c_sdat_in, i2c_sclk};

    // A filtered level only flips after FILTER_LEN consecutive synchronized
    // samples disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_filt   <= '1;
            r_filt_d <= '1;
            r_fcnt   <= '0;
        end else begin
            r_sync1  <= w_pins;
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            for (int unsigned i = 0; i < 2; i++) begin
                if (r_sync2[i] != r_filt[i]) begin
                    if (r_fcnt[i] == FILT_LAST) begin
                        r_filt[i] <= r_sync2[i];
                        r_fcnt[i] <= '0;
                    end else begin
                        r_fcnt[i] <= r_fcnt[i] + 3'd1;
                    end
                end else begin
                    r_fcnt[i] <= '0;
                end
            end
        end
    end

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;
    logic w_sda;

    assign w_sda      = r_filt[1];
    assign w_scl_rise =  r_filt[0] & ~r_filt_d[0];
    assign w_scl_fall = ~r_filt[0] &  r_filt_d[0];
    // SCL must be high both before and after the SDA change; an SDA change in
    // the same filtered sample as an SCL change is therefore never a START/STOP.
    assign w_start = r_filt_d[0] & r_filt[0] &  r_filt_d[1] & ~r_filt[1];
    assign w_stop  = r_filt_d[0] & r_filt[0] & ~r_filt_d[1] &  r_filt[1];

    state_t      r_state;
    logic [2:0]  r_bit_cnt;
    logic        r_got8;
    logic [7:0]  r_shift;
    logic [7:0]  r_hi;
    logic        r_oe;
    logic        r_wr;
    logic [7:0]  r_addr;
    logic [15:0] r_wdata;
    logic        r_busy;
    logic [7:0]  r_nack;
`ifdef I2C_SLAVE_READ_EN
    logic        r_rd;
    logic        r_mack;
    logic [15:0] r_rd_word;
`else
    logic        w_unused_rdata;
    assign w_unused_rdata = ^reg_rdata;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_got8    <= 1'b0;
            r_shift   <= '0;
            r_hi      <= '0;
            r_oe      <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_busy    <= 1'b0;
            r_nack    <= '0;
`ifdef I2C_SLAVE_READ_EN
            r_rd      <= 1'b0;
            r_mack    <= 1'b1;
            r_rd_word <= '0;
`endif
        end else begin
            r_wr <= 1'b0;
            if (w_stop) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_oe    <= 1'b0;
            end else if (w_start) begin
                r_state   <= ADDR;
                r_bit_cnt <= '0;
                r_got8    <= 1'b0;
                r_busy    <= 1'b1;
                r_oe      <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
                r_rd      <= 1'b0;
`endif
            end else begin
                case (r_state)
                    ADDR, SUB, DHI, DLO: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) r_got8 <= 1'b1;
                        end else if (w_scl_fall && r_got8) begin
                            // SCL fall after bit 8 opens the ACK slot.
                            r_got8    <= 1'b0;
                            r_bit_cnt <= '0;
                            case (r_state)
                                ADDR: begin
                                    if (r_shift == ADDR_WR) begin
                                        r_oe    <= 1'b1;
                                        r_state <= ADDR_ACK;
`ifdef I2C_SLAVE_READ_EN
                                    end else if (r_shift == ADDR_RD) begin
                                        r_oe    <= 1'b1;
                                        r_rd    <= 1'b1;
                                        r_state <= ADDR_ACK;
`endif
                                    end else begin
                                        if (r_nack != 8'hFF) r_nack <= r_nack + 8'd1;
                                        r_state <= WAIT_STOP;
                                    end
                                end
                                SUB: begin
                                    r_oe    <= 1'b1;
                                    r_addr  <= r_shift;
                                    r_state <= SUB_ACK;
                                end
                                DHI: begin
                                    r_oe    <= 1'b1;
                                    r_hi    <= r_shift;
                                    r_state <= DHI_ACK;
                                end
                                default: begin
                                    r_oe    <= 1'b1;
                                    r_wdata <= {r_hi, r_shift};
                                    r_wr    <= 1'b1;
                                    r_state <= DLO_ACK;
                                end
                            endcase
                        end
                    end
                    ADDR_ACK: begin
                        if (w_scl_fall) begin
`ifdef I2C_SLAVE_READ_EN
                            if (r_rd) begin
                                // First read bit must be on SDA before the next SCL rise.
                                r_rd_word <= reg_rdata;
                                r_oe      <= ~reg_rdata[15];
                                r_state   <= RD_HI;
                            end else begin
                                r_oe    <= 1'b0;
                                r_state <= SUB;
                            end
`else
                            r_oe    <= 1'b0;
                            r_state <= SUB;
`endif
                        end
                    end
                    SUB_ACK: begin
                        if (w_scl_fall) begin
                            r_oe    <= 1'b0;
                            r_state <= DHI;
                        end
                    end
                    DHI_ACK: begin
                        if (w_scl_fall) begin
                            r_oe    <= 1'b0;
                            r_state <= DLO;
                        end
                    end
                    DLO_ACK: begin
                        // Address advances after the strobe so reg_addr is
                        // stable while reg_wr is high.
                        if (w_scl_fall) begin
                            r_oe    <= 1'b0;
                            r_addr  <= r_addr + 8'd1;
                            r_state <= DHI;
                        end
                    end
`ifdef I2C_SLAVE_READ_EN
                    RD_HI, RD_LO: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) r_got8 <= 1'b1;
                        end else if (w_scl_fall) begin
                            // Shifting on every fall leaves the low byte in
                            // [15:8] once the high byte has gone out.
                            r_rd_word <= {r_rd_word[14:0], 1'b0};
                            if (r_got8) begin
                                r_got8    <= 1'b0;
                                r_bit_cnt <= '0;
                                r_oe      <= 1'b0;
                                r_mack    <= 1'b1;
                                r_state   <= (r_state == RD_HI) ? RD_HI_MACK : RD_LO_MACK;
                            end else begin
                                r_oe <= ~r_rd_word[14];
                            end
                        end
                    end
                    RD_HI_MACK: begin
                        if (w_scl_rise) begin
                            r_mack <= w_sda;
                        end else if (w_scl_fall) begin
                            if (!r_mack) begin
                                r_oe    <= ~r_rd_word[15];
                                r_state <= RD_LO;
                            end else begin
                                r_state <= WAIT_STOP;
                            end
                        end
                    end
                    RD_LO_MACK: begin
                        // Address steps on the ACK rise so reg_rdata for the
                        // next word has settled by the following SCL fall.
                        if (w_scl_rise) begin
                            r_mack <= w_sda;
                            if (!w_sda) r_addr <= r_addr + 8'd1;
                        end else if (w_scl_fall) begin
                            if (!r_mack) begin
                                r_rd_word <= reg_rdata;
                                r_oe      <= ~reg_rdata[15];
                                r_state   <= RD_HI;
                            end else begin
                                r_state <= WAIT_STOP;
                            end
                        end
                    end
`endif
                    default: begin
                    end
                endcase
            end
        end
    end

    assign i2c_sdat_oe = r_oe;
    assign reg_wr      = r_wr;
    assign reg_addr    = r_addr;
    assign reg_wdata   = r_wdata;
    assign busy        = r_busy;
    assign nack_count  = r_nack;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Testbench for i2c_reg_slave: bit-banged I2C master, scoreboard of expected
// register writes, and per-scenario checks. Clock is 2 MHz so a quarter SCL
// period of 25 cycles gives 20 kHz SCL.
`timescale 1ns/1ps
module tb_i2c_reg_slave;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_line;
    logic        i2c_sdat_oe;
    logic        reg_wr;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata = 16'hA5F0;
    logic        busy;
    logic [7:0]  nack_count;

    assign sda_line = sda_m & ~i2c_sdat_oe;

    i2c_reg_slave #(.SLAVE_ADDR(7'h5D), .FILTER_LEN(3)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .i2c_sclk    (scl_m),
        .i2c_sdat_in (sda_line),
        .i2c_sdat_oe (i2c_sdat_oe),
        .reg_wr      (reg_wr),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .busy        (busy),
        .nack_count  (nack_count)
    );

    always #250 clock = ~clock;

    int tests_run = 0;
    int tests_failed = 0;
    int q = 25;
    int oe_seen = 0;
    int busy_rises = 0;
    logic [23:0] exp_q[$];

    // Scoreboard monitor: every strobe must match the oldest expected write.
    initial begin
        logic        busy_d;
        logic [23:0] e;
        busy_d = 1'b0;
        forever begin
            @(negedge clock);
            if (reg_wr === 1'b1) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL strobe_unexpected: got addr=%h data=%h, required no strobe", reg_addr, reg_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({reg_addr, reg_wdata} !== e) begin
                        tests_failed++;
                        $display("FAIL strobe_value: got addr=%h data=%h, required addr=%h data=%h",
                                 reg_addr, reg_wdata, e[23:16], e[15:0]);
                    end
                end
            end
            if (i2c_sdat_oe === 1'b1) oe_seen++;
            if (busy === 1'b1 && busy_d === 1'b0) busy_rises++;
            busy_d = busy;
        end
    end

    initial begin
        #(200000 * 500);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_cyc(q);
        scl_m = 1'b1; wait_cyc(q);
        sda_m = 1'b0; wait_cyc(q);
        scl_m = 1'b0; wait_cyc(q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_cyc(q);
        scl_m = 1'b1; wait_cyc(q);
        sda_m = 1'b1; wait_cyc(2 * q);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; wait_cyc(q);
            scl_m = 1'b1; wait_cyc(2 * q);
            scl_m = 1'b0; wait_cyc(q);
        end
    endtask

    task automatic ack_slot(output logic ack);
        sda_m = 1'b1; wait_cyc(q);
        scl_m = 1'b1; wait_cyc(q);
        ack = sda_line;
        wait_cyc(q);
        scl_m = 1'b0; wait_cyc(q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b);
        ack_slot(ack);
    endtask

    task automatic write_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                               input int n, input string name);
        logic [7:0] bytes [6];
        logic ack;
        bytes = '{b0, b1, b2, b3, b4, b5};
        i2c_start();
        for (int i = 0; i < n; i++) begin
            send_byte(bytes[i], ack);
            tests_run++;
            if (ack !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s_ack%0d: got sda=%b, required 0", name, i, ack);
            end
        end
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_busy_mid: got %b, required 1", name, busy);
        end
        i2c_stop();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_busy_end: got %b, required 0", name, busy);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_missing_strobe: got %0d pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wait_cyc(5);
        tests_run++;
        if ({i2c_sdat_oe, reg_wr, busy} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got oe/wr/busy=%b, required 000", {i2c_sdat_oe, reg_wr, busy});
        end
        tests_run++;
        if ({reg_addr, reg_wdata, nack_count} !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_regs: got addr=%h wdata=%h nack=%h, required 0", reg_addr, reg_wdata, nack_count);
        end
        reset_n = 1'b1;
        wait_cyc(10);
    endtask

    task automatic test_single_write();
        q = 25;
        exp_q.push_back({8'h09, 16'h012C});
        write_bytes(8'hBA, 8'h09, 8'h01, 8'h2C, 8'h00, 8'h00, 4, "single");
        tests_run++;
        if (reg_addr !== 8'h0A) begin
            tests_failed++;
            $display("FAIL single_addr_inc: got %h, required 0a", reg_addr);
        end
    endtask

    task automatic test_burst_wrap();
        q = 25;
        exp_q.push_back({8'hFF, 16'h1122});
        exp_q.push_back({8'h00, 16'h3344});
        write_bytes(8'hBA, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 6, "burst");
        tests_run++;
        if (reg_addr !== 8'h01) begin
            tests_failed++;
            $display("FAIL burst_addr_wrap: got %h, required 01", reg_addr);
        end
    endtask

    task automatic test_partial_no_strobe();
        q = 25;
        write_bytes(8'hBA, 8'h30, 8'h55, 8'h00, 8'h00, 8'h00, 3, "partial");
    endtask

    task automatic test_nack();
        logic ack;
        logic [7:0] a;
        int exp_nack;
        q = 4;
        oe_seen = 0;
        exp_nack = 0;
        for (int n = 1; n <= 300; n++) begin
            a = 8'h90;
`ifndef I2C_SLAVE_READ_EN
            if (n == 2) a = 8'hBB;
`endif
            i2c_start();
            send_byte(a, ack);
            tests_run++;
            if (ack !== 1'b1) begin
                tests_failed++;
                $display("FAIL nack_ack_%0d: got sda=%b for addr %h, required 1", n, ack, a);
            end
            i2c_stop();
            exp_nack = (exp_nack == 255) ? 255 : exp_nack + 1;
            if (n == 1 || n == 2 || n == 254 || n == 255 || n == 300) begin
                tests_run++;
                if (nack_count !== 8'(exp_nack)) begin
                    tests_failed++;
                    $display("FAIL nack_count_%0d: got %0d, required %0d", n, nack_count, exp_nack);
                end
            end
        end
        tests_run++;
        if (oe_seen != 0) begin
            tests_failed++;
            $display("FAIL nack_sda_drive: got %0d driven cycles, required 0", oe_seen);
        end
        q = 25;
    endtask

    task automatic test_glitch();
        int base;
        scl_m = 1'b1; sda_m = 1'b1;
        wait_cyc(20);
        base = busy_rises;
        sda_m = 1'b0; wait_cyc(2);
        sda_m = 1'b1; wait_cyc(20);
        tests_run++;
        if (busy_rises != base || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_2cyc: got rises=%0d busy=%b, required rises=%0d busy=0", busy_rises, busy, base);
        end
        sda_m = 1'b0; wait_cyc(4);
        sda_m = 1'b1; wait_cyc(20);
        tests_run++;
        if (busy_rises != base + 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_4cyc: got rises=%0d busy=%b, required rises=%0d busy=0", busy_rises, busy, base + 1);
        end
        sda_m = 1'b0; scl_m = 1'b0; wait_cyc(20);
        sda_m = 1'b1; scl_m = 1'b1; wait_cyc(20);
        tests_run++;
        if (busy_rises != base + 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL simultaneous_edges: got rises=%0d busy=%b, required rises=%0d busy=0", busy_rises, busy, base + 1);
        end
    endtask

    task automatic test_reset_mid_transfer();
        logic ack;
        q = 25;
        i2c_start();
        send_byte(8'hBA, ack);
        send_byte(8'h20, ack);
        send_bits(8'hC0);
        sda_m = 1'b1; wait_cyc(q);
        scl_m = 1'b1; wait_cyc(q);
        tests_run++;
        if (i2c_sdat_oe !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_ack_before: got oe=%b, required 1", i2c_sdat_oe);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (i2c_sdat_oe !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_async: got oe=%b busy=%b, required 0 0", i2c_sdat_oe, busy);
        end
        wait_cyc(5);
        reset_n = 1'b1;
        wait_cyc(20);
        tests_run++;
        if (reg_addr !== 8'h00 || nack_count !== 8'h00 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL midreset_state: got addr=%h nack=%0d pending=%0d, required 00 0 0",
                     reg_addr, nack_count, exp_q.size());
        end
        exp_q.push_back({8'h20, 16'hC03D});
        write_bytes(8'hBA, 8'h20, 8'hC0, 8'h3D, 8'h00, 8'h00, 4, "after_reset");
    endtask

`ifdef I2C_SLAVE_READ_EN
    task automatic read_byte(output logic [7:0] b, input logic nack);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_cyc(q);
            scl_m = 1'b1; wait_cyc(q);
            b[i] = sda_line;
            wait_cyc(q);
            scl_m = 1'b0;
        end
        wait_cyc(q);
        sda_m = nack; wait_cyc(q);
        scl_m = 1'b1; wait_cyc(2 * q);
        scl_m = 1'b0; wait_cyc(q);
        sda_m = 1'b1;
    endtask

    task automatic test_read();
        logic ack;
        logic [7:0] b;
        q = 25;
        i2c_start();
        send_byte(8'hBA, ack);
        send_byte(8'h22, ack);
        i2c_start();
        send_byte(8'hBB, ack);
        tests_run++;
        if (ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_addr_ack: got sda=%b, required 0", ack);
        end
        read_byte(b, 1'b0);
        tests_run++;
        if (b !== 8'hA5) begin
            tests_failed++;
            $display("FAIL read_hi: got %h, required a5", b);
        end
        read_byte(b, 1'b1);
        tests_run++;
        if (b !== 8'hF0) begin
            tests_failed++;
            $display("FAIL read_lo: got %h, required f0", b);
        end
        tests_run++;
        if (i2c_sdat_oe !== 1'b0 || reg_addr !== 8'h22) begin
            tests_failed++;
            $display("FAIL read_release: got oe=%b addr=%h, required 0 22", i2c_sdat_oe, reg_addr);
        end
        i2c_stop();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_busy_end: got %b, required 0", busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_burst_wrap();
        test_partial_no_strobe();
        test_glitch();
`ifdef I2C_SLAVE_READ_EN
        test_read();
`endif
        test_reset_mid_transfer();
        test_nack();
        wait_cyc(10);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
